// File: rtl/mux_pkg.sv
// mux_pkg: shared state encoding and limits for the mux_sel_pipe block
package mux_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } mux_state_t;
  localparam int MUX_MAX_IN = 16;
endpackage

// File: rtl/mux_sel_comb.sv
// mux_sel_comb: NUM_IN:1 word select, zero output and illegal flag for out-of-range select
module mux_sel_comb #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    illegal
);
  always_comb begin
    illegal = int'(sel) >= NUM_IN;
    word = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (sel == SEL_W'(k)) word = data[k*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: pipelined N:1 select with two-entry skid buffer and valid/ready handshakes.
// Define MUX_SEL_ERR_EN to enable the sticky illegal-select flag.
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_flag,
  input  logic                    err_clr
);
  mux_state_t state, state_nxt;
  logic [WIDTH-1:0] word, main_data, skid_data;
  logic [SEL_W-1:0] main_sel, skid_sel;
  logic illegal, acc, rel, load_main, load_skid, from_skid;

  mux_sel_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_sel (
    .data(in_data), .sel(in_sel), .word(word), .illegal(illegal)
  );

  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data  = main_data;
  assign out_sel   = main_sel;
  assign acc       = in_valid && in_ready;
  assign rel       = out_valid && out_ready;
  assign load_main = acc && (state == EMPTY || rel);
  assign load_skid = acc && state == ONE && !rel;
  assign from_skid = state == TWO && rel;

  always_comb
    state_nxt = state == EMPTY ? (acc ? ONE : EMPTY) :
                state == ONE   ? (load_skid ? TWO : (!acc && rel) ? EMPTY : ONE) :
                                 (rel ? ONE : TWO);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_data <= word;
        main_sel  <= in_sel;
      end else if (from_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
      end
      if (load_skid) begin
        skid_data <= word;
        skid_sel  <= in_sel;
      end
    end

`ifdef MUX_SEL_ERR_EN
  // a new illegal accept outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_flag <= 1'b0;
    else err_flag <= (acc && illegal) ? 1'b1 : err_clr ? 1'b0 : err_flag;
`else
  assign err_flag = &{1'b0, err_clr, illegal};
`endif
endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised N-input, W-bit select multiplexer with a registered, back-pressurable output stage. It generalises the two-input 5-bit destination/operand selector into a pipelined block. The selected word and its select index travel through a two-entry skid buffer with valid/ready handshakes. It sits between the decode stage and register write-back, where stalls from downstream must not drop a selected word.

## Interface
- WIDTH, 5, data word width in bits (≥1)
- NUM_IN, 2, number of input channels (2..16)
- SEL_W, $clog2(NUM_IN), select width (derived; do not override)
---
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  NUM_IN*WIDTH  packed channels; channel k occupies [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  channel index
- in_valid  input  1  upstream offers in_data/in_sel
- in_ready  output  1  block can accept this cycle
- out_data  output  WIDTH  selected word
- out_sel  output  SEL_W  index the word was taken from
- out_valid  output  1  out_data/out_sel valid
- out_ready  input  1  downstream accepts
- err_flag  output  1  sticky illegal-select flag (see Configuration)
- err_clr  input  1  synchronous clear of err_flag

## Operation
- Accept when in_valid && in_ready. Capture in_data[in_sel*WIDTH +: WIDTH] and in_sel.
- Out-of-range select (in_sel ≥ NUM_IN, possible when NUM_IN is not a power of 2): the captured word is all-zero, out_sel = in_sel, and the transfer still completes.
- Storage is a main register (drives the outputs) plus one skid register. States:
  - EMPTY
  - ONE: main full
  - TWO: main and skid full
- Transitions, with acc = input accept and rel = out_valid && out_ready:
  - EMPTY: acc → ONE.
  - ONE: acc && !rel → TWO (word to skid). acc && rel → ONE (main reloads). !acc && rel → EMPTY. Otherwise hold.
  - TWO: rel → ONE (skid moves to main). No accept is possible in TWO.
- in_ready = (state != TWO). It is registered: it depends only on state, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Order is strict FIFO. No word is ever dropped or duplicated.
- While out_valid && !out_ready, out_data and out_sel are held stable.

## Timing
- Latency 1 cycle: a word accepted at edge n appears on the outputs after edge n, provided the block was EMPTY or releasing.
- Sustained throughput is 1 word/cycle when out_ready is held high.
- Reset (asynchronous assert, synchronous-to-clk release): state=EMPTY, out_valid=0, out_data=0, out_sel=0, in_ready=1, err_flag=0.
- Reset mid-transfer discards both entries. There is no recovery of the in-flight word.
- Simultaneous accept and release in ONE keeps the state at ONE, and the new word replaces main on the same edge.
- err_clr and a new illegal accept in the same cycle: set wins, so err_flag=1.

## Configuration
- Macro MUX_SEL_ERR_EN.
- Defined: err_flag sets on any accepted transfer with in_sel ≥ NUM_IN, and holds until err_clr or reset.
- Undefined: err_flag is tied to 0 and err_clr is ignored. Ports stay present so instantiations do not change. The zero-data behaviour for illegal selects is unchanged.

## Structure
- Shared package mux_pkg holds:
  - state encoding typedef mux_state_t (EMPTY=2'b00, ONE=2'b01, TWO=2'b10)
  - constant MUX_MAX_IN=16
- One sub-module, mux_sel_comb: pure combinational NUM_IN:1 select with out-of-range zeroing and an illegal-select indication.
- The top level holds the state machine, main/skid registers and the err logic.

## Test plan
- Reset with WIDTH=5, NUM_IN=2 → out_valid=0, out_data=0, in_ready=1, err_flag=0. Drive in_data={5'h1A,5'h05}, in_sel=1, out_ready=1 → out_data=5'h1A, out_sel=1, one cycle later.
- NUM_IN=4, out_ready=1, stream sel=0,1,2,3 on consecutive cycles → outputs appear in the same order, one per cycle, and in_ready stays 1.
- Accept word A, then drop out_ready for 3 cycles while presenting B and C → B goes to skid and in_ready=0, C is not accepted, and A stays stable. Raise out_ready → outputs A, B, then C, with no loss.
- NUM_IN=3, accept sel=3 → out_data=0, out_sel=3. With MUX_SEL_ERR_EN, err_flag=1 until err_clr pulses. Without it, err_flag stays 0.
- Assert rst_n=0 mid-cycle while in TWO → outputs clear immediately (before the next edge), and the block resumes in EMPTY after release.
